sha2_apb_master_adapter: RTL and testbench

- Requester side of the SHA2 APB conduit. Converts single-beat conduit write/read requests into APB4 master transfers.
- Provides APB4 SETUP/ACCESS sequencing, wait-state handling, and slave-error reporting, plus a bounded-wait timeout.
- Used by the SHA2 DMA/test-sequencer path to drive APB register files, including the SHA2 core's own slave port.

---
 rtl/sha2_apb_pkg.sv | 35 +++
 rtl/sha2_apb_master_adapter.sv | 148 ++++++++++++++
 tb/tb_sha2_apb_master_adapter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_apb_pkg.sv
// Shared types for the SHA2 APB conduit: FSM states, address width and
// the completion-response flags reported back to the requester.
package sha2_apb_pkg;

    localparam int APB_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Completion flags. The data-width dependent part of the response
    // (rdata) is attached by the user, which knows its own D_WIDTH.
    typedef struct packed {
        logic ack;
        logic rvalid;
        logic err;
        logic timeout;
    } apb_resp_flags_t;

    // Builds the completion flags for a finished transfer: writes pulse ack,
    // reads pulse rvalid, and err/timeout qualify that pulse.
    function automatic apb_resp_flags_t make_resp_flags(input logic is_write,
                                                        input logic err,
                                                        input logic timeout);
        apb_resp_flags_t f;
        f.ack     = is_write;
        f.rvalid  = ~is_write;
        f.err     = err;
        f.timeout = timeout;
        return f;
    endfunction

endpackage

// File: rtl/sha2_apb_master_adapter.sv
// Requester side of the SHA2 APB conduit: turns single-beat conduit
// requests into APB4 SETUP/ACCESS transfers with wait-state handling,
// slave-error reporting and an optional bounded-wait timeout.
module sha2_apb_master_adapter
    import sha2_apb_pkg::*;
#(
    parameter int D_WIDTH        = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  con_wr,
    input  logic                  con_rd,
    input  logic [APB_ADDR_W-1:0] con_addr,
    input  logic [D_WIDTH-1:0]    con_wdata,
    input  logic [D_WIDTH/8-1:0]  con_wbyte_enable,
    output logic                  con_ready,
    output logic                  con_wr_ack,
    output logic                  con_read_valid,
    output logic [D_WIDTH-1:0]    con_rdata,
    output logic                  con_slv_error,
    output logic                  con_timeout,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [D_WIDTH-1:0]    pwdata,
    output logic [D_WIDTH/8-1:0]  pstrb,
    input  logic                  pready,
    input  logic [D_WIDTH-1:0]    prdata,
    input  logic                  pslverr
);

    localparam int STRB_W = D_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        apb_resp_flags_t    flags;
        logic [D_WIDTH-1:0] rdata;
    } apb_resp_t;

    apb_state_e            state, state_next;
    apb_resp_t             resp, resp_next;
    logic [CNT_W-1:0]      wait_count, wait_count_next;
    logic                  psel_next, penable_next, pwrite_next, ready_next;
    logic [APB_ADDR_W-1:0] paddr_next;
    logic [D_WIDTH-1:0]    pwdata_next;
    logic [STRB_W-1:0]     pstrb_next;

    assign con_wr_ack     = resp.flags.ack;
    assign con_read_valid = resp.flags.rvalid;
    assign con_slv_error  = resp.flags.err;
    assign con_timeout    = resp.flags.timeout;
    assign con_rdata      = resp.rdata;

    // Next-state and next-output logic; every output is then registered so
    // the APB and conduit sides both see clean flop outputs.
    always_comb begin
        state_next      = state;
        psel_next       = psel;
        penable_next    = penable;
        pwrite_next     = pwrite;
        paddr_next      = paddr;
        pwdata_next     = pwdata;
        pstrb_next      = pstrb;
        ready_next      = con_ready;
        wait_count_next = wait_count;
        resp_next.flags = '0;
        resp_next.rdata = resp.rdata;

        case (state)
            IDLE: begin
                ready_next = 1'b1;
                // A write wins over a simultaneous read; reads carry no
                // strobes or write data on the bus.
                if (con_wr || con_rd) begin
                    state_next      = SETUP;
                    psel_next       = 1'b1;
                    penable_next    = 1'b0;
                    ready_next      = 1'b0;
                    paddr_next      = con_addr;
                    pwrite_next     = con_wr;
                    pwdata_next     = con_wr ? con_wdata : '0;
                    pstrb_next      = con_wr ? con_wbyte_enable : '0;
                    wait_count_next = '0;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_next      = IDLE;
                    psel_next       = 1'b0;
                    penable_next    = 1'b0;
                    ready_next      = 1'b1;
                    resp_next.flags = make_resp_flags(pwrite, pslverr, 1'b0);
                    resp_next.rdata = pwrite ? resp.rdata : prdata;
                end else if ((TIMEOUT_CYCLES > 0) && (wait_count == CNT_LAST)) begin
                    state_next      = IDLE;
                    psel_next       = 1'b0;
                    penable_next    = 1'b0;
                    ready_next      = 1'b1;
                    resp_next.flags = make_resp_flags(pwrite, 1'b1, 1'b1);
                    resp_next.rdata = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    wait_count_next = wait_count + CNT_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
                ready_next   = 1'b1;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any transfer.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            con_ready  <= 1'b1;
            wait_count <= '0;
            resp       <= '0;
        end else begin
            state      <= state_next;
            psel       <= psel_next;
            penable    <= penable_next;
            pwrite     <= pwrite_next;
            paddr      <= paddr_next;
            pwdata     <= pwdata_next;
            pstrb      <= pstrb_next;
            con_ready  <= ready_next;
            wait_count <= wait_count_next;
            resp       <= resp_next;
        end
    end

endmodule

// File: tb/tb_sha2_apb_master_adapter.sv
// Directed self-checking bench for sha2_apb_master_adapter (32-bit data,
// 16-cycle timeout). The APB slave side is driven directly per cycle.
module tb_sha2_apb_master_adapter;

    logic        pclk = 1'b0;
    logic        preset;
    logic        con_wr, con_rd;
    logic [11:0] con_addr;
    logic [31:0] con_wdata;
    logic [3:0]  con_wbyte_enable;
    logic        con_ready, con_wr_ack, con_read_valid;
    logic [31:0] con_rdata;
    logic        con_slv_error, con_timeout;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int check_count = 0;
    int pass_count  = 0;

    sha2_apb_master_adapter #(.D_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .con_wr(con_wr), .con_rd(con_rd), .con_addr(con_addr),
        .con_wdata(con_wdata), .con_wbyte_enable(con_wbyte_enable),
        .con_ready(con_ready), .con_wr_ack(con_wr_ack),
        .con_read_valid(con_read_valid), .con_rdata(con_rdata),
        .con_slv_error(con_slv_error), .con_timeout(con_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        con_wr           = wr;
        con_rd           = rd;
        con_addr         = addr;
        con_wdata        = wdata;
        con_wbyte_enable = strb;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  pen_cnt;
        int  lat;
        int  pulses;
        bit  done;
        bit  strb_bad;

        preset  = 1'b1;
        pready  = 1'b1;
        prdata  = 32'h0;
        pslverr = 1'b0;
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        step();
        step();
        preset = 1'b0;

        // Reset state
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_pwrite", pwrite, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_pwdata", pwdata, 0);
        checkOutput("rst_pstrb", pstrb, 0);
        checkOutput("rst_ready", con_ready, 1);
        checkOutput("rst_rdata", con_rdata, 0);
        checkOutput("rst_pulses", {con_wr_ack, con_read_valid, con_slv_error, con_timeout}, 0);

        // Zero-wait write
        $display("[TB] write, zero wait states");
        applyStimulus(1'b1, 1'b0, 12'h0A4, 32'hDEADBEEF, 4'b0011);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        checkOutput("wr_t1_psel", psel, 1);
        checkOutput("wr_t1_penable", penable, 0);
        checkOutput("wr_t1_ready", con_ready, 0);
        checkOutput("wr_t1_pwrite", pwrite, 1);
        checkOutput("wr_t1_paddr", paddr, 12'h0A4);
        checkOutput("wr_t1_pwdata", pwdata, 32'hDEADBEEF);
        checkOutput("wr_t1_pstrb", pstrb, 4'b0011);
        step();
        checkOutput("wr_t2_psel", psel, 1);
        checkOutput("wr_t2_penable", penable, 1);
        checkOutput("wr_t2_pwdata", pwdata, 32'hDEADBEEF);
        checkOutput("wr_t2_pstrb", pstrb, 4'b0011);
        checkOutput("wr_t2_ack", con_wr_ack, 0);
        step();
        checkOutput("wr_t3_ack", con_wr_ack, 1);
        checkOutput("wr_t3_err", con_slv_error, 0);
        checkOutput("wr_t3_psel", psel, 0);
        checkOutput("wr_t3_ready", con_ready, 1);
        step();
        checkOutput("wr_t4_ack", con_wr_ack, 0);
        checkOutput("wr_idle_paddr", paddr, 12'h0A4);

        // Read with three wait states
        $display("[TB] read, three wait states");
        pready = 1'b0;
        prdata = 32'h12345678;
        applyStimulus(1'b0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'hF);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        checkOutput("rd_pstrb", pstrb, 0);
        checkOutput("rd_pwdata", pwdata, 0);
        checkOutput("rd_pwrite", pwrite, 0);
        checkOutput("rd_paddr", paddr, 12'h010);
        pen_cnt  = 0;
        lat      = 0;
        done     = 1'b0;
        strb_bad = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (penable) pen_cnt++;
            if (psel && pstrb != 4'h0) strb_bad = 1'b1;
            pready = (pen_cnt == 4);
            step();
            if (con_read_valid) begin
                done = 1'b1;
                lat  = c + 2;
            end
        end
        checkOutput("rd_done", done, 1);
        checkOutput("rd_latency", lat, 6);
        checkOutput("rd_penable_cycles", pen_cnt, 4);
        checkOutput("rd_strb_stable", strb_bad, 0);
        checkOutput("rd_rdata", con_rdata, 32'h12345678);
        checkOutput("rd_err", con_slv_error, 0);
        checkOutput("rd_timeout", con_timeout, 0);
        pready = 1'b1;
        step();
        checkOutput("rd_pulse_once", con_read_valid, 0);

        // Write answered with pslverr
        $display("[TB] write with slave error");
        pslverr = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'h004, 32'h00000055, 4'hF);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        step();
        step();
        pslverr = 1'b0;
        checkOutput("err_ack", con_wr_ack, 1);
        checkOutput("err_slv", con_slv_error, 1);
        checkOutput("err_timeout", con_timeout, 0);
        checkOutput("err_rdata_hold", con_rdata, 32'h12345678);
        step();
        checkOutput("err_clear", con_slv_error, 0);

        // Timeout on a read
        $display("[TB] read timeout");
        pready = 1'b0;
        prdata = 32'hCAFEF00D;
        applyStimulus(1'b0, 1'b1, 12'h020, 32'h0, 4'h0);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        pen_cnt = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (penable) pen_cnt++;
            step();
            if (con_read_valid) done = 1'b1;
        end
        checkOutput("to_done", done, 1);
        checkOutput("to_access_cycles", pen_cnt, 16);
        checkOutput("to_psel", psel, 0);
        checkOutput("to_err", con_slv_error, 1);
        checkOutput("to_flag", con_timeout, 1);
        checkOutput("to_rdata", con_rdata, 0);
        pready = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'h030, 32'h00000001, 4'h1);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        checkOutput("to_after_timeout_clear", con_timeout, 0);
        checkOutput("to_next_psel", psel, 1);
        step();
        step();
        checkOutput("to_next_ack", con_wr_ack, 1);
        checkOutput("to_next_err", con_slv_error, 0);

        // Simultaneous write/read, then back-to-back reads
        $display("[TB] simultaneous request and back-to-back reads");
        applyStimulus(1'b1, 1'b1, 12'h040, 32'hA5A5A5A5, 4'hF);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        checkOutput("both_pwrite", pwrite, 1);
        checkOutput("both_pstrb", pstrb, 4'hF);
        step();
        step();
        checkOutput("both_ack", con_wr_ack, 1);
        checkOutput("both_no_rvalid", con_read_valid, 0);
        prdata = 32'h0BADCAFE;
        applyStimulus(1'b0, 1'b1, 12'h050, 32'h0, 4'hF);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 7) con_rd = 1'b0;
            checkOutput($sformatf("b2b_psel_%0d", i), psel, (i % 3) != 0);
            checkOutput($sformatf("b2b_rvalid_%0d", i), con_read_valid, (i % 3) == 0);
            if (i == 1) checkOutput("b2b_pstrb", pstrb, 0);
            if ((i % 3) == 0) checkOutput($sformatf("b2b_rdata_%0d", i), con_rdata, 32'h0BADCAFE);
        end
        step();
        checkOutput("b2b_idle_psel", psel, 0);

        // Reset in the second ACCESS wait cycle
        $display("[TB] reset during ACCESS");
        pready = 1'b0;
        applyStimulus(1'b0, 1'b1, 12'h060, 32'h0, 4'h0);
        step();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        step();
        step();
        checkOutput("rst_mid_penable_before", penable, 1);
        preset = 1'b1;
        step();
        preset = 1'b0;
        checkOutput("rst_mid_psel", psel, 0);
        checkOutput("rst_mid_penable", penable, 0);
        checkOutput("rst_mid_ready", con_ready, 1);
        pready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (con_wr_ack || con_read_valid) pulses++;
            step();
        end
        checkOutput("rst_mid_no_pulse", pulses, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
